rv_multicycle_sequencer: RTL and testbench

//  Multi-cycle control sequencer for the shared-bus datapath: register file, ALU operand latches A/B,
//  and ALU broadcast onto the bus. Accepts one RV32I instruction via a valid/ready handshake and

---
 rtl/rv_multicycle_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_rv_multicycle_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle control sequencer for a shared-bus RV32I datapath (OP, OP-IMM, LUI).
// One instruction is accepted in IDLE and walked through OPA -> OPB -> WB.
module rv_multicycle_sequencer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned ALU_SEL_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [31:0]          machine_code,
    output logic [ALU_SEL_W-1:0] alu_function_sel,
    output logic                 alu_store_1,
    output logic                 alu_store_2,
    output logic                 alu_broadcast,
    output logic [REG_IDX_W-1:0] register_index,
    output logic                 register_read_enable,
    output logic                 register_write_enable,
    output logic [XLEN-1:0]      imm,
    output logic                 imm_EN,
    output logic                 done,
    output logic                 illegal
);

    localparam logic [6:0] OpcOp  = 7'b0110011;
    localparam logic [6:0] OpcImm = 7'b0010011;
    localparam logic [6:0] OpcLui = 7'b0110111;

    localparam logic [ALU_SEL_W-1:0] AluOr   = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] AluAnd  = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] AluXor  = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] AluSll  = ALU_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] AluSrl  = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] AluSra  = ALU_SEL_W'(6);
    localparam logic [ALU_SEL_W-1:0] AluSlt  = ALU_SEL_W'(7);
    localparam logic [ALU_SEL_W-1:0] AluSltu = ALU_SEL_W'(8);
    localparam logic [ALU_SEL_W-1:0] AluAdd  = ALU_SEL_W'(12);
    localparam logic [ALU_SEL_W-1:0] AluSub  = ALU_SEL_W'(13);

    typedef enum logic [1:0] {StIdle, StOpa, StOpb, StWb} state_e;

    state_e      state_q, state_d;
    logic [31:0] ir_q;
    logic        illegal_q;
    logic        accept;
    logic        legal;

    // Register fields above the implemented file depth make the instruction illegal.
    function automatic logic idx_ok(input logic [4:0] f);
        return (32'(f) >> REG_IDX_W) == 32'd0;
    endfunction

    assign instr_ready = (state_q == StIdle) && !reset;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        legal = 1'b0;
        unique case (machine_code[6:0])
            OpcOp: begin
                legal = (machine_code[31:25] == 7'h00) ||
                        ((machine_code[31:25] == 7'h20) &&
                         ((machine_code[14:12] == 3'b000) || (machine_code[14:12] == 3'b101)));
                legal = legal && idx_ok(machine_code[19:15]) && idx_ok(machine_code[24:20]) &&
                        idx_ok(machine_code[11:7]);
            end
            OpcImm: begin
                unique case (machine_code[14:12])
                    3'b001:  legal = (machine_code[31:25] == 7'h00);
                    3'b101:  legal = (machine_code[31:25] == 7'h00) ||
                                     (machine_code[31:25] == 7'h20);
                    default: legal = 1'b1;
                endcase
                legal = legal && idx_ok(machine_code[19:15]) && idx_ok(machine_code[11:7]);
            end
            OpcLui:  legal = idx_ok(machine_code[11:7]);
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= accept && !legal;
            if (accept) begin
                ir_q <= machine_code;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && legal) state_d = StOpa;
            StOpa:   state_d = StOpb;
            StOpb:   state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic                 is_op, is_lui, is_shift;
    logic [ALU_SEL_W-1:0] alu_code;

    assign is_op    = (ir_q[6:0] == OpcOp);
    assign is_lui   = (ir_q[6:0] == OpcLui);
    assign is_shift = (ir_q[13:12] == 2'b01);

    always_comb begin
        alu_code = AluAdd;
        if (!is_lui) begin
            unique case (ir_q[14:12])
                3'b000:  alu_code = (is_op && ir_q[30]) ? AluSub : AluAdd;
                3'b001:  alu_code = AluSll;
                3'b010:  alu_code = AluSlt;
                3'b011:  alu_code = AluSltu;
                3'b100:  alu_code = AluXor;
                3'b101:  alu_code = ir_q[30] ? AluSra : AluSrl;
                3'b110:  alu_code = AluOr;
                default: alu_code = AluAnd;
            endcase
        end
    end

    always_comb begin
        alu_function_sel      = '0;
        alu_store_1           = 1'b0;
        alu_store_2           = 1'b0;
        alu_broadcast         = 1'b0;
        register_index        = '0;
        register_read_enable  = 1'b0;
        register_write_enable = 1'b0;
        imm                   = '0;
        imm_EN                = 1'b0;
        done                  = 1'b0;
        illegal               = illegal_q && !reset;
        if (!reset) begin
            unique case (state_q)
                StOpa: begin
                    alu_function_sel = alu_code;
                    alu_store_1      = 1'b1;
                    if (is_lui) begin
                        imm_EN    = 1'b1;
                        imm       = {XLEN{ir_q[31]}};
                        imm[31:0] = {ir_q[31:12], 12'b0};
                    end else begin
                        register_index       = REG_IDX_W'(ir_q[19:15]);
                        register_read_enable = 1'b1;
                    end
                end
                StOpb: begin
                    alu_function_sel = alu_code;
                    alu_store_2      = 1'b1;
                    if (is_op) begin
                        register_index       = REG_IDX_W'(ir_q[24:20]);
                        register_read_enable = 1'b1;
                    end else if (is_lui) begin
                        imm_EN = 1'b1;
                    end else begin
                        imm_EN = 1'b1;
                        if (is_shift) begin
                            imm[4:0] = ir_q[24:20];
                        end else begin
                            imm       = {XLEN{ir_q[31]}};
                            imm[11:0] = ir_q[31:20];
                        end
                    end
                end
                StWb: begin
                    alu_function_sel      = alu_code;
                    alu_broadcast         = 1'b1;
                    register_index        = REG_IDX_W'(ir_q[11:7]);
                    register_write_enable = (ir_q[11:7] != 5'd0);
                    done                  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Directed testbench for rv_multicycle_sequencer: per-scenario tasks compare the packed
// output vector against hand-computed per-cycle expectations.
module tb_rv_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] machine_code = 32'h0;
    logic        instr_ready;
    logic [4:0]  alu_function_sel;
    logic        alu_store_1, alu_store_2, alu_broadcast;
    logic [4:0]  register_index;
    logic        register_read_enable, register_write_enable;
    logic [31:0] imm;
    logic        imm_EN, done, illegal;

    rv_multicycle_sequencer #(
        .XLEN      (32),
        .REG_IDX_W (5),
        .ALU_SEL_W (5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .machine_code          (machine_code),
        .alu_function_sel      (alu_function_sel),
        .alu_store_1           (alu_store_1),
        .alu_store_2           (alu_store_2),
        .alu_broadcast         (alu_broadcast),
        .register_index        (register_index),
        .register_read_enable  (register_read_enable),
        .register_write_enable (register_write_enable),
        .imm                   (imm),
        .imm_EN                (imm_EN),
        .done                  (done),
        .illegal               (illegal)
    );

    always #5 clk = ~clk;

    // {ready, sel, st1, st2, bc, idx, rd_en, we, imm, imm_en, done, illegal}
    logic [50:0] obs;
    assign obs = {instr_ready, alu_function_sel, alu_store_1, alu_store_2, alu_broadcast,
                  register_index, register_read_enable, register_write_enable, imm, imm_EN,
                  done, illegal};

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [50:0] ev(input logic rdy, input logic [4:0] sel, input logic s1,
                                       input logic s2, input logic bc, input logic [4:0] idx,
                                       input logic re, input logic we, input logic [31:0] im,
                                       input logic ie, input logic dn, input logic il);
        return {rdy, sel, s1, s2, bc, idx, re, we, im, ie, dn, il};
    endfunction

    localparam logic [50:0] IdleReady = 51'h4_0000_0000_0000;

    task automatic test_reset;
        #1;
        n_total++;
        if (obs !== 51'h0) $display("FAIL reset_hold: got %h want %h", obs, 51'h0);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (obs !== IdleReady) $display("FAIL reset_release: got %h want %h", obs, IdleReady);
        else n_pass++;
    endtask

    task automatic test_addi;
        logic [50:0] exp [5];
        exp[0] = IdleReady;
        exp[1] = ev(0, 12, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
        exp[2] = ev(0, 12, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0);
        exp[3] = ev(0, 12, 0, 0, 1, 5, 0, 1, 32'h0, 0, 1, 0);
        exp[4] = IdleReady;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_valid = (i == 0);
            if (i == 0) machine_code = 32'hFFF0_8293;
            #1;
            n_total++;
            if (obs !== exp[i]) $display("FAIL addi c%0d: got %h want %h", i, obs, exp[i]);
            else n_pass++;
        end
    endtask

    // machine_code is scrambled after acceptance; the sequence must not notice.
    task automatic test_sub_sltu;
        logic [50:0] exp [10];
        logic [31:0] code [2];
        code[0] = 32'h4020_81B3;
        code[1] = 32'h0020_B233;
        exp[0] = IdleReady;
        exp[1] = ev(0, 13, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
        exp[2] = ev(0, 13, 0, 1, 0, 2, 1, 0, 32'h0, 0, 0, 0);
        exp[3] = ev(0, 13, 0, 0, 1, 3, 0, 1, 32'h0, 0, 1, 0);
        exp[4] = IdleReady;
        exp[5] = IdleReady;
        exp[6] = ev(0, 8, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
        exp[7] = ev(0, 8, 0, 1, 0, 2, 1, 0, 32'h0, 0, 0, 0);
        exp[8] = ev(0, 8, 0, 0, 1, 4, 0, 1, 32'h0, 0, 1, 0);
        exp[9] = IdleReady;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_valid  = (i % 5 == 0);
            machine_code = (i % 5 == 0) ? code[i / 5] : 32'hFFFF_FFFF ^ (32'(i) << 7);
            #1;
            n_total++;
            if (obs !== exp[i]) $display("FAIL sub_sltu c%0d: got %h want %h", i, obs, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_lui_srai;
        logic [50:0] exp [10];
        logic [31:0] code [2];
        code[0] = 32'h1234_53B7;
        code[1] = 32'h41F0_D313;
        exp[0] = IdleReady;
        exp[1] = ev(0, 12, 1, 0, 0, 0, 0, 0, 32'h1234_5000, 1, 0, 0);
        exp[2] = ev(0, 12, 0, 1, 0, 0, 0, 0, 32'h0, 1, 0, 0);
        exp[3] = ev(0, 12, 0, 0, 1, 7, 0, 1, 32'h0, 0, 1, 0);
        exp[4] = IdleReady;
        exp[5] = IdleReady;
        exp[6] = ev(0, 6, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
        exp[7] = ev(0, 6, 0, 1, 0, 0, 0, 0, 32'h0000_001F, 1, 0, 0);
        exp[8] = ev(0, 6, 0, 0, 1, 6, 0, 1, 32'h0, 0, 1, 0);
        exp[9] = IdleReady;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            instr_valid = (i % 5 == 0);
            if (i % 5 == 0) machine_code = code[i / 5];
            #1;
            n_total++;
            if (obs !== exp[i]) $display("FAIL lui_srai c%0d: got %h want %h", i, obs, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal;
        logic [50:0] exp [3];
        logic [31:0] code [2];
        code[0] = 32'h0000_0003;
        code[1] = 32'h4030_9293;
        exp[0] = IdleReady;
        exp[1] = ev(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        exp[2] = IdleReady;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                instr_valid = (i == 0);
                if (i == 0) machine_code = code[w];
                #1;
                n_total++;
                if (obs !== exp[i])
                    $display("FAIL illegal w%0d c%0d: got %h want %h", w, i, obs, exp[i]);
                else n_pass++;
            end
        end
    endtask

    // add x0,x1,x2 held valid: re-accepted every 4 cycles, done at cycles 3 and 7.
    task automatic test_back_to_back;
        logic [9:0]  done_mask = '0;
        logic [50:0] wb_exp;
        wb_exp = ev(0, 12, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            instr_valid  = 1'b1;
            machine_code = 32'h0020_8033;
            #1;
            done_mask[k] = done;
            if (k == 3) begin
                n_total++;
                if (obs !== wb_exp) $display("FAIL x0_wb: got %h want %h", obs, wb_exp);
                else n_pass++;
            end
        end
        n_total++;
        if (done_mask !== 10'b00_1000_1000)
            $display("FAIL b2b_done_mask: got %b want %b", done_mask, 10'b00_1000_1000);
        else n_pass++;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (obs !== IdleReady) $display("FAIL b2b_drain: got %h want %h", obs, IdleReady);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        logic [50:0] exp [5];
        logic        saw_done = 1'b0;
        @(negedge clk);
        instr_valid  = 1'b1;
        machine_code = 32'hFFF0_8293;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_total++;
        if (obs !== 51'h0) $display("FAIL rst_in_opb: got %h want %h", obs, 51'h0);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | done;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (obs !== IdleReady) $display("FAIL rst_release_ready: got %h want %h", obs, IdleReady);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | done;
        end
        n_total++;
        if (saw_done !== 1'b0) $display("FAIL rst_no_done: got %b want %b", saw_done, 1'b0);
        else n_pass++;
        exp[0] = IdleReady;
        exp[1] = ev(0, 13, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0, 0);
        exp[2] = ev(0, 13, 0, 1, 0, 2, 1, 0, 32'h0, 0, 0, 0);
        exp[3] = ev(0, 13, 0, 0, 1, 3, 0, 1, 32'h0, 0, 1, 0);
        exp[4] = IdleReady;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_valid = (i == 0);
            if (i == 0) machine_code = 32'h4020_81B3;
            #1;
            n_total++;
            if (obs !== exp[i]) $display("FAIL post_rst c%0d: got %h want %h", i, obs, exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_sltu();
        test_lui_srai();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
